counter2421_ctrl: RTL and testbench

Run/hold/clear controller and sequencer for a cascade of 2421 (Aiken) coded decade digit counters, i.e. a stopwatch/event-timer core. Internal prescaler on clk generates the count tick; controller manages start/stop/clear/load commands, up/down direction, digit carry/borrow ripple, terminal-count detection and wrap-or-halt policy. Output feeds the 2421 display/decoder path.

---
 rtl/counter2421_ctrl.sv | 121 ++++++++++++
 tb/tb_counter2421_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/counter2421_ctrl.sv
// counter2421_ctrl: run/hold/clear sequencer for a cascade of 2421 (Aiken) coded decade digits
// with an internal tick prescaler, up/down ripple and terminal-count wrap-or-halt policy.
module counter2421_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int WRAP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_bcd,
    input  logic                up_dn,
    output logic [4*DIGITS-1:0] count_2421,
    output logic                running,
    output logic                done,
    output logic                tc,
    output logic                err
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d, nxt, enc_load;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tc_q, tc_d, err_q, err_d;
    logic                valid, carry, tick;
    logic [3:0]          dg;

    // Aiken digits 5..9 are the BCD value offset by 6, 0..4 are identical.
    function automatic logic [3:0] enc(input logic [3:0] d);
        return d < 4'd5 ? d : d + 4'd6;
    endfunction

    function automatic logic [3:0] dec(input logic [3:0] a);
        return a < 4'd5 ? a : a - 4'd6;
    endfunction

    always_comb begin
        valid    = 1'b1;
        enc_load = '0;
        nxt      = cnt_q;
        carry    = 1'b1;
        dg       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i+:4] > 4'd9) valid = 1'b0;
            enc_load[4*i+:4] = enc(load_bcd[4*i+:4]);
            dg = dec(cnt_q[4*i+:4]);
            if (carry) begin
                if (up_dn) begin
                    carry = dg == 4'd9;
                    nxt[4*i+:4] = enc(carry ? 4'd0 : dg + 4'd1);
                end else begin
                    carry = dg == 4'd0;
                    nxt[4*i+:4] = enc(carry ? 4'd9 : dg - 4'd1);
                end
            end
        end
        tick    = state_q == S_RUN && pre_q == P_MAX;
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            pre_d   = '0;
            state_d = S_IDLE;
        end else if (load) begin
            if (valid) begin
                cnt_d   = enc_load;
                pre_d   = '0;
                state_d = state_q == S_DONE ? S_HOLD : state_q;
            end else begin
                err_d = 1'b1;
            end
        end else if (stop) begin
            state_d = state_q == S_RUN ? S_HOLD : state_q;
        end else if (start && state_q == S_IDLE) begin
            state_d = S_RUN;
            pre_d   = '0;
        end else if (start && state_q == S_HOLD) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                tc_d    = carry;
                cnt_d   = carry && WRAP == 0 ? cnt_q : nxt;
                state_d = carry && WRAP == 0 ? S_DONE : S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count_2421 = cnt_q;
    assign running    = state_q == S_RUN;
    assign done       = state_q == S_DONE;
    assign tc         = tc_q;
    assign err        = err_q;
endmodule

// File: tb/tb_counter2421_ctrl.sv
// tb_counter2421_ctrl: directed bench driving a wrapping and a halting counter
// (DIGITS=2, PRESCALE=3) from shared inputs.
module tb_counter2421_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, stop, clear, load, up_dn;
    logic [7:0] load_bcd;
    logic [7:0] cnt_w, cnt_h;
    logic       run_w, run_h, done_w, done_h, tc_w, tc_h, err_w, err_h;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    counter2421_ctrl #(.DIGITS(2), .PRESCALE(3), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_bcd(load_bcd), .up_dn(up_dn), .count_2421(cnt_w), .running(run_w),
        .done(done_w), .tc(tc_w), .err(err_w));

    counter2421_ctrl #(.DIGITS(2), .PRESCALE(3), .WRAP(0)) dut_h (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
        .load_bcd(load_bcd), .up_dn(up_dn), .count_2421(cnt_h), .running(run_h),
        .done(done_h), .tc(tc_h), .err(err_h));

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {start, stop, clear, load, load_bcd} = '0;
        up_dn = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("reset_cnt", cnt_w, 8'h00);
        chk("reset_flags", {run_w, done_w, tc_w, err_w, run_h, done_h, tc_h, err_h}, 8'h00);

        start = 1'b1; step(); start = 1'b0;
        chk("run_after_start", {7'd0, run_w}, 8'h01);
        step(2);
        chk("no_tick_E2", cnt_w, 8'h00);
        step();
        chk("tick_E3", cnt_w, 8'h01);
        step(3);
        chk("tick_E6", cnt_w, 8'h02);

        load_bcd = 8'h09; load = 1'b1; step(); load = 1'b0;
        chk("load_09", cnt_w, 8'h0F);
        step(3);
        chk("up_09_to_10", cnt_w, 8'h10);

        load_bcd = 8'h45; load = 1'b1; step(); load = 1'b0;
        chk("load_45", cnt_w, 8'h4B);
        step(3);
        chk("up_45_to_46", cnt_w, 8'h4C);

        up_dn = 1'b0;
        load_bcd = 8'h10; load = 1'b1; step(); load = 1'b0;
        step(3);
        chk("dn_10_to_09", cnt_w, 8'h0F);
        up_dn = 1'b1;

        load_bcd = 8'h99; load = 1'b1; step(); load = 1'b0;
        chk("load_99", cnt_h, 8'hFF);
        step(2);
        chk("tc_idle_before", {6'd0, tc_w, tc_h}, 8'h00);
        step();
        chk("wrap_cnt", cnt_w, 8'h00);
        chk("wrap_flags", {4'd0, run_w, done_w, tc_w, err_w}, 8'b0000_1010);
        chk("halt_cnt", cnt_h, 8'hFF);
        chk("halt_flags", {4'd0, run_h, done_h, tc_h, err_h}, 8'b0000_0110);
        step();
        chk("tc_one_cycle", {6'd0, tc_w, tc_h}, 8'h00);
        start = 1'b1; step(); start = 1'b0;
        chk("done_ignores_start", {6'd0, run_h, done_h}, 8'h01);

        load_bcd = 8'h3A; load = 1'b1; step(); load = 1'b0;
        chk("bad_load_err", {6'd0, err_w, err_h}, 8'h03);
        chk("bad_load_cnt", cnt_h, 8'hFF);
        step();
        chk("err_one_cycle", {6'd0, err_w, err_h}, 8'h00);

        load_bcd = 8'h37; load = 1'b1; step(); load = 1'b0;
        chk("load_in_done_cnt", cnt_h, 8'h3D);
        chk("load_in_done_hold", {6'd0, run_h, done_h}, 8'h00);

        clear = 1'b1; step(); clear = 1'b0;
        chk("clear_cnt", cnt_w, 8'h00);
        chk("clear_idle", {6'd0, run_w, run_h}, 8'h00);

        start = 1'b1; step(); start = 1'b0;
        step();
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_hold", {6'd0, run_w, run_h}, 8'h00);
        step(20);
        chk("hold_frozen", cnt_w, 8'h00);
        start = 1'b1; step(); start = 1'b0;
        chk("resume_run", {7'd0, run_w}, 8'h01);
        step();
        chk("resume_no_tick", cnt_w, 8'h00);
        step();
        chk("resume_tick", cnt_w, 8'h01);

        start = 1'b1; stop = 1'b1; step(); {start, stop} = 2'b00;
        chk("stop_wins", {7'd0, run_w}, 8'h00);

        start = 1'b1; step(); start = 1'b0;
        load_bcd = 8'h55; load = 1'b1; clear = 1'b1; step(); {load, clear} = 2'b00;
        chk("clear_over_load_cnt", cnt_w, 8'h00);
        chk("clear_over_load_flags", {4'd0, run_w, done_w, tc_w, err_w}, 8'h00);

        start = 1'b1; step(); start = 1'b0;
        step(4);
        chk("pre_rst_cnt", cnt_w, 8'h01);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_cnt", cnt_w, 8'h00);
        chk("rst_mid_flags", {run_w, done_w, tc_w, err_w, run_h, done_h, tc_h, err_h}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
